// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider: registered divided clock plus period-start tick.
// Ratio changes and stop requests land only on period boundaries, so the output never has a runt pulse.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int MIN_DIV = 2,
  parameter int DEF_DIV = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_div,
  output logic [1:0]       fsm_state,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);

  state_t           state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] pend_div;
  logic             pend_valid;

  logic             accept;
  logic             legal;
  logic             last;
  logic [CNT_W:0]   half;
  logic [CNT_W:0]   k_inc;

  // The supply pins carry no logic; folding them here keeps them visibly consumed.
  wire unused_supply = VDD ^ VSS;

  // cfg handshake: a request is consumed on any edge where cfg_valid and cfg_ready are both 1;
  // cfg_valid may be held or dropped freely, and cfg_ready is low only while the pending slot is full.
  assign accept = cfg_valid & cfg_ready;
  assign legal  = (cfg_div >= MIN_V);
  assign last   = (k == active_div - ONE);
  // Extra bit so ceil(N/2) and k+1 do not overflow when N is all-ones.
  assign half   = ({1'b0, active_div} + ONE_W) >> 1;
  assign k_inc  = {1'b0, k} + ONE_W;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      active_div <= DEF_V;
      pend_valid <= 1'b0;
      pend_div   <= '0;
    end else begin
      cfg_err <= accept & ~legal;
      case (state)
        IDLE: begin
          // A value pended on the boundary that entered IDLE has no further boundary to wait for.
          if (pend_valid)          active_div <= pend_div;
          else if (accept && legal) active_div <= cfg_div;
          pend_valid <= 1'b0;
          cfg_ready  <= 1'b1;
          if (enable) begin
            state   <= RUN;
            k       <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RUN, STOP: begin
          if (last) begin
            if (pend_valid) active_div <= pend_div;
            if (accept && legal) begin
              pend_valid <= 1'b1;
              pend_div   <= cfg_div;
              cfg_ready  <= 1'b0;
            end else begin
              pend_valid <= 1'b0;
              cfg_ready  <= 1'b1;
            end
            k <= '0;
            if (enable) begin
              state   <= RUN;
              clk_out <= 1'b1;
              tick    <= 1'b1;
            end else begin
              state   <= IDLE;
              clk_out <= 1'b0;
              tick    <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            if (accept && legal) begin
              pend_valid <= 1'b1;
              pend_div   <= cfg_div;
              cfg_ready  <= 1'b0;
            end
            k       <= k + ONE;
            clk_out <= (k_inc < half);
            tick    <= 1'b0;
            state   <= enable ? RUN : STOP;
          end
        end
        default: begin
          state   <= IDLE;
          k       <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: directed stimulus pushes the expected output word per cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_clk_div_ctrl;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, clk_out, tick, busy;
  logic [7:0] active_div;
  logic [1:0] fsm_state;
  wire        vdd;
  wire        vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  clk_div_ctrl #(.CNT_W(8), .MIN_DIV(2), .DEF_DIV(9)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick), .busy(busy),
    .active_div(active_div), .fsm_state(fsm_state), .VDD(vdd), .VSS(vss)
  );

  always #5 clk = ~clk;

  // Drive inputs for the coming edge, then land 1 time unit after it.
  task automatic step(input logic en, input logic cv, input logic [7:0] cd);
    enable = en;
    cfg_valid = cv;
    cfg_div = cd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic hi(input int n, input int k);
    return (k < (n + 1) / 2);
  endfunction

  // Word layout: {active_div, cfg_err, cfg_ready, busy, tick, clk_out}
  task automatic push_run(input int n, input int k, input logic rdy, input logic err);
    exp_q.push_back({8'(n), err, rdy, 1'b1, (k == 0), hi(n, k)});
  endtask

  task automatic push_idle(input logic rdy, input logic err, input int div);
    exp_q.push_back({8'(div), err, rdy, 3'b000});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {active_div, cfg_err, cfg_ready, busy, tick, clk_out};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL out_word t=%0t got div=%0d err=%b rdy=%b busy=%b tick=%b clk=%b (state=%0d) exp div=%0d err=%b rdy=%b busy=%b tick=%b clk=%b",
                 $time, g[12:5], g[4], g[3], g[2], g[1], g[0], fsm_state,
                 e[12:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    // reset state
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0); push_idle(1, 0, 9);
    reset = 1'b0;
    step(0, 0, 0); push_idle(1, 0, 9);

    // default ratio 9: 1-cycle latency, 5 high / 4 low
    for (int i = 0; i < 18; i++) begin step(1, 0, 0); push_run(9, i % 9, 1, 0); end

    // pend a request, then reset mid high phase: everything back to reset values
    step(1, 1, 3); push_run(9, 0, 0, 0);
    step(1, 0, 0); push_run(9, 1, 0, 0);
    reset = 1'b1;
    step(1, 0, 0); push_idle(1, 0, 9);
    reset = 1'b0;
    step(0, 0, 0); push_idle(1, 0, 9);

    // IDLE request applies immediately, ready stays high
    step(0, 1, 4); push_idle(1, 0, 4);
    step(0, 0, 0); push_idle(1, 0, 4);
    for (int i = 0; i < 8; i++) begin step(1, 0, 0); push_run(4, i % 4, 1, 0); end

    // request on the boundary edge is pended for a whole period
    step(1, 1, 9); push_run(4, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin step(1, 0, 0); push_run(4, k, 0, 0); end
    step(1, 0, 0); push_run(9, 0, 1, 0);
    step(1, 0, 0); push_run(9, 1, 1, 0);
    step(1, 0, 0); push_run(9, 2, 1, 0);

    // request 2 at k=2 of N=9: period still 9 long, then 1/0
    step(1, 1, 2); push_run(9, 3, 0, 0);
    for (int k = 4; k < 9; k++) begin step(1, 0, 0); push_run(9, k, 0, 0); end
    for (int i = 0; i < 4; i++) begin step(1, 0, 0); push_run(2, i % 2, 1, 0); end

    // switch to 5, drop enable at k=1: period completes then IDLE
    step(1, 1, 5); push_run(2, 0, 0, 0);
    step(1, 0, 0); push_run(2, 1, 0, 0);
    step(1, 0, 0); push_run(5, 0, 1, 0);
    step(1, 0, 0); push_run(5, 1, 1, 0);
    for (int k = 2; k < 5; k++) begin step(0, 0, 0); push_run(5, k, 1, 0); end
    step(0, 0, 0); push_idle(1, 0, 5);
    step(0, 0, 0); push_idle(1, 0, 5);

    // drop at k=1, reassert at k=3: no gap
    step(1, 0, 0); push_run(5, 0, 1, 0);
    step(1, 0, 0); push_run(5, 1, 1, 0);
    step(0, 0, 0); push_run(5, 2, 1, 0);
    step(0, 0, 0); push_run(5, 3, 1, 0);
    step(1, 0, 0); push_run(5, 4, 1, 0);
    step(1, 0, 0); push_run(5, 0, 1, 0);

    // illegal ratios 1 and 0 while running: consumed, err pulse, ratio unchanged
    step(1, 1, 1); push_run(5, 1, 1, 1);
    step(1, 0, 0); push_run(5, 2, 1, 0);
    step(1, 1, 0); push_run(5, 3, 1, 1);
    step(1, 0, 0); push_run(5, 4, 1, 0);
    step(1, 0, 0); push_run(5, 0, 1, 0);
    for (int k = 1; k < 5; k++) begin step(0, 0, 0); push_run(5, k, 1, 0); end
    step(0, 0, 0); push_idle(1, 0, 5);
    step(0, 1, 0); push_idle(1, 1, 5);
    step(0, 0, 0); push_idle(1, 0, 5);

    // all-ones ratio: 128 high, 127 low, no early wrap
    step(0, 1, 255); push_idle(1, 0, 255);
    for (int i = 0; i < 256; i++) begin step(1, 0, 0); push_run(255, i % 255, 1, 0); end
    for (int k = 1; k < 255; k++) begin step(0, 0, 0); push_run(255, k, 1, 0); end
    step(0, 0, 0); push_idle(1, 0, 255);
    step(0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
